// File: rtl/useq_pkg.sv
// Shared definitions for the microprogrammed sequencer: sequencing opcodes,
// FSM state encoding and microword width helpers.
package useq_pkg;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_DISPATCH = 3'd2;
  localparam logic [2:0] OP_BR_T     = 3'd3;
  localparam logic [2:0] OP_BR_F     = 3'd4;
  localparam logic [2:0] OP_CALL     = 3'd5;
  localparam logic [2:0] OP_RET      = 3'd6;
  localparam logic [2:0] OP_HALT     = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  function automatic int sel_width(input int nflags);
    return $clog2(nflags);
  endfunction

  // Microword: {next_addr, seq_op[3], cond_sel, ctrl}
  function automatic int mw_width(input int uaddr_w, input int nflags, input int ctrl_w);
    return uaddr_w + 3 + sel_width(nflags) + ctrl_w;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Bounded return-address LIFO for CALL/RET; the top entry is readable
// combinationally so a RET can pop and jump in the same cycle.
module useq_stack #(
  parameter int WIDTH = 7,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PTR_W-1:0] sp;
  logic [PTR_W-1:0] sp_dec;
  logic [WIDTH-1:0] mem [DEPTH];

  assign sp_dec = sp - PTR_W'(1);
  assign full   = (sp == PTR_W'(DEPTH));
  assign empty  = (sp == '0);
  assign top    = mem[sp_dec[IDX_W-1:0]];

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + PTR_W'(1);
    end else if (pop && !empty) begin
      sp <= sp_dec;
    end
  end

  // NOTE: storage arrays carry no reset; only the pointer decides validity,
  // and leaving the array unreset lets it map onto plain RAM cells.
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[sp[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed sequencer with a run-time writable control store, flag
// branches, opcode dispatch, bounded call/return and a start/done/error handshake.
module micro_sequencer
  import useq_pkg::*;
#(
  parameter  int CTRL_W      = 32,
  parameter  int UADDR_W     = 7,
  parameter  int OPCODE_W    = 7,
  parameter  int NFLAGS      = 4,
  parameter  int STACK_DEPTH = 4,
  localparam int SEL_W       = sel_width(NFLAGS),
  localparam int MW          = mw_width(UADDR_W, NFLAGS, CTRL_W)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                ld_we,
  input  logic [UADDR_W-1:0]  ld_addr,
  input  logic [MW-1:0]       ld_data,
  input  logic [OPCODE_W-1:0] ir_opcode,
  input  logic [NFLAGS-1:0]   flags,
  output logic [CTRL_W-1:0]   ctrl,
  output logic [UADDR_W-1:0]  upc,
  output logic                busy,
  output logic                done,
  output logic                error
);

  localparam int                 DEPTH      = 2 ** UADDR_W;
  localparam logic [UADDR_W-1:0] START_ADDR = '0;

  state_t state, state_next;

  logic [MW-1:0]       store [DEPTH];
  logic [UADDR_W-1:0]  next_addr, upc_inc, target, upc_next, stack_top;
  logic [2:0]          seq_op;
  logic [SEL_W-1:0]    cond_sel;
  logic [2**SEL_W-1:0] flag_ext;
  logic [CTRL_W-1:0]   ctrl_next;
  logic                cond, accept_start, fault;
  logic                push, pop, clear, stack_full, stack_empty;

  assign next_addr = store[upc][MW-1 -: UADDR_W];
  assign seq_op    = store[upc][CTRL_W+SEL_W +: 3];
  assign cond_sel  = store[upc][CTRL_W +: SEL_W];
  assign upc_inc   = upc + UADDR_W'(1);

  // Selector codes beyond the implemented flags fall back to flag 0.
  for (genvar g = 0; g < 2 ** SEL_W; g++) begin : g_flag
    assign flag_ext[g] = flags[(g < NFLAGS) ? g : 0];
  end
  assign cond = flag_ext[cond_sel];

  assign accept_start = (state != ST_RUN) && start && !ld_we;
  assign fault = (state == ST_RUN) &&
                 (((seq_op == OP_CALL) && stack_full) || ((seq_op == OP_RET) && stack_empty));

  always_ff @(posedge clk) begin
    if (ld_we && (state != ST_RUN)) begin
      store[ld_addr] <= ld_data;
    end
  end

  useq_stack #(
    .WIDTH (UADDR_W),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .push      (push),
    .pop       (pop),
    .push_data (upc_inc),
    .top       (stack_top),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      upc   <= '0;
      ctrl  <= '0;
    end else begin
      state <= state_next;
      upc   <= upc_next;
      ctrl  <= ctrl_next;
    end
  end

  // NOTE: every combinational output gets a default before any branch,
  // otherwise an uncovered path infers a latch.
  always_comb begin
    target = upc_inc;
    case (seq_op)
      OP_JUMP, OP_CALL: target = next_addr;
      OP_DISPATCH:      target = UADDR_W'(ir_opcode);
      OP_BR_T:          target = cond ? next_addr : upc_inc;
      OP_BR_F:          target = cond ? upc_inc : next_addr;
      OP_RET:           target = stack_top;
      default:          target = upc_inc;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_RUN: begin
        if (fault)                     state_next = ST_ERR;
        else if (seq_op == OP_HALT)    state_next = ST_DONE;
      end
      default: if (accept_start)       state_next = ST_RUN;
    endcase
  end

  always_comb begin
    upc_next  = upc;
    ctrl_next = ctrl;
    push      = 1'b0;
    pop       = 1'b0;
    clear     = 1'b0;
    if (state == ST_RUN) begin
      if (fault || (seq_op == OP_HALT)) begin
        ctrl_next = '0;
      end else begin
        upc_next  = target;
        ctrl_next = store[target][CTRL_W-1:0];
        push      = (seq_op == OP_CALL);
        pop       = (seq_op == OP_RET);
      end
    end else if (accept_start) begin
      upc_next  = START_ADDR;
      ctrl_next = store[START_ADDR][CTRL_W-1:0];
      clear     = 1'b1;
    end
    busy  = (state == ST_RUN);
    done  = (state == ST_DONE);
    error = (state == ST_ERR);
  end

endmodule

// File: tb/tb_micro_sequencer.sv
// Directed self-checking bench for micro_sequencer: sequencing, branches,
// dispatch, call/return depth, wrap, load gating and asynchronous reset.
module tb_micro_sequencer;
  import useq_pkg::*;

  localparam int MW = 44;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          ld_we = 1'b0;
  logic [6:0]    ld_addr = '0;
  logic [MW-1:0] ld_data = '0;
  logic [6:0]    ir_opcode = '0;
  logic [3:0]    flags = '0;
  logic [31:0]   ctrl;
  logic [6:0]    upc;
  logic          busy, done, error;

  int checks = 0;
  int errors = 0;

  micro_sequencer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ld_we     (ld_we),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ir_opcode (ir_opcode),
    .flags     (flags),
    .ctrl      (ctrl),
    .upc       (upc),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  function automatic logic [MW-1:0] mw(input logic [6:0] na, input logic [2:0] op,
                                       input logic [1:0] sel, input logic [31:0] c);
    return {na, op, sel, c};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [6:0] addr, input logic [MW-1:0] word);
    ld_we   = 1'b1;
    ld_addr = addr;
    ld_data = word;
    tick();
    ld_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic step_upc(input string tag, input logic [6:0] exp);
    tick();
    check(tag, upc, exp);
  endtask

  initial begin
    #12 rst_n = 1'b1;
    tick();
    check("rst_ctrl", ctrl, 0);
    check("rst_upc", upc, 0);
    check("rst_flags", {busy, done, error}, 3'b000);

    // Straight-line NEXT x3 then HALT
    load(0, mw(0, OP_NEXT, 0, 32'd1));
    load(1, mw(0, OP_NEXT, 0, 32'd2));
    load(2, mw(0, OP_NEXT, 0, 32'd3));
    load(3, mw(0, OP_HALT, 0, 32'd4));
    check("idle_after_load", busy, 0);
    pulse_start();
    check("seq_c1", ctrl, 1);
    check("seq_busy", busy, 1);
    tick(); check("seq_c2", ctrl, 2);
    tick(); check("seq_c3", ctrl, 3);
    tick(); check("seq_c4", ctrl, 4);
    check("seq_u3", upc, 3);
    tick();
    check("seq_done", {busy, done, error}, 3'b010);
    check("seq_done_ctrl", ctrl, 0);
    tick(); check("done_sticky", done, 1);

    // Loads during RUN are ignored
    pulse_start();
    ld_we = 1'b1; ld_addr = 2; ld_data = mw(0, OP_NEXT, 0, 32'hBAD);
    tick();
    ld_we = 1'b0;
    check("gate_u1", upc, 1);
    tick(); check("gate_run_c3", ctrl, 3);
    tick(); tick();
    check("gate_done", done, 1);
    pulse_start(); tick(); tick();
    check("gate_rerun_c3", ctrl, 3);
    do_reset();

    // BR_T / BR_F
    load(0, mw(10, OP_BR_T, 0, 32'h50));
    load(10, mw(0, OP_HALT, 0, 32'hA));
    flags = 4'b0001;
    pulse_start();
    check("brt_u0", upc, 0);
    check("brt_c0", ctrl, 32'h50);
    tick();
    check("brt_taken_u", upc, 10);
    check("brt_taken_c", ctrl, 32'hA);
    do_reset();
    flags = 4'b0000;
    pulse_start(); step_upc("brt_fall", 1);
    check("brt_fall_c", ctrl, 2);
    do_reset();
    load(0, mw(10, OP_BR_F, 0, 32'h51));
    flags = 4'b0001;
    pulse_start(); step_upc("brf_fall", 1);
    do_reset();
    flags = 4'b0000;
    pulse_start(); step_upc("brf_taken", 10);
    do_reset();
    load(0, mw(10, OP_BR_T, 2, 32'h52));
    flags = 4'b0100;
    pulse_start(); step_upc("brt_sel2_taken", 10);
    do_reset();
    flags = 4'b1011;
    pulse_start(); step_upc("brt_sel2_fall", 1);
    do_reset();
    flags = 4'b0000;

    // DISPATCH
    load(42, mw(0, OP_HALT, 0, 32'h42A));
    load(0, mw(0, OP_DISPATCH, 0, 32'h60));
    ir_opcode = 7'd42;
    pulse_start();
    ir_opcode = 7'd42;
    step_upc("disp_upc", 42);
    check("disp_ctrl", ctrl, 32'h42A);
    tick(); check("disp_done", done, 1);

    // Single CALL/RET
    load(0, mw(5, OP_JUMP, 0, 32'h100));
    load(5, mw(20, OP_CALL, 0, 32'h105));
    load(6, mw(0, OP_HALT, 0, 32'h106));
    load(20, mw(0, OP_RET, 0, 32'h120));
    pulse_start();
    step_upc("call_jump", 5);
    step_upc("call_tgt", 20);
    check("call_tgt_c", ctrl, 32'h120);
    step_upc("call_ret", 6);
    check("call_ret_c", ctrl, 32'h106);
    tick(); check("call_done", {busy, done, error}, 3'b010);

    // Four nested calls unwind in reverse order
    load(0, mw(30, OP_CALL, 0, 32'h200));
    load(30, mw(40, OP_CALL, 0, 32'h230));
    load(40, mw(50, OP_CALL, 0, 32'h240));
    load(50, mw(60, OP_CALL, 0, 32'h250));
    load(60, mw(0, OP_RET, 0, 32'h260));
    load(51, mw(0, OP_RET, 0, 32'h251));
    load(41, mw(0, OP_RET, 0, 32'h241));
    load(31, mw(0, OP_RET, 0, 32'h231));
    pulse_start();
    step_upc("nest_c1", 30);
    step_upc("nest_c2", 40);
    step_upc("nest_c3", 50);
    step_upc("nest_c4", 60);
    step_upc("nest_r4", 51);
    step_upc("nest_r3", 41);
    step_upc("nest_r2", 31);
    step_upc("nest_r1", 1);
    check("nest_r1_c", ctrl, 2);
    check("nest_no_err", error, 0);
    tick(); tick(); tick();
    check("nest_done", done, 1);

    // Fifth nested CALL overflows
    load(60, mw(70, OP_CALL, 0, 32'h270));
    pulse_start();
    tick(); tick(); tick(); tick();
    check("ovf_pre_upc", upc, 60);
    tick();
    check("ovf_state", {busy, done, error}, 3'b001);
    check("ovf_ctrl", ctrl, 0);
    check("ovf_upc", upc, 60);
    tick(); check("ovf_sticky", error, 1);

    // RET at top level underflows; start from ERR clears error and stack
    load(0, mw(0, OP_RET, 0, 32'h300));
    pulse_start();
    check("unf_start", {busy, done, error}, 3'b100);
    check("unf_start_c", ctrl, 32'h300);
    tick();
    check("unf_state", {busy, done, error}, 3'b001);
    check("unf_ctrl", ctrl, 0);
    check("unf_upc", upc, 0);

    // Address wrap then asynchronous reset mid-run
    load(0, mw(127, OP_JUMP, 0, 32'h310));
    load(127, mw(0, OP_NEXT, 0, 32'h7F));
    pulse_start();
    step_upc("wrap_127", 127);
    check("wrap_127_c", ctrl, 32'h7F);
    step_upc("wrap_0", 0);
    check("wrap_0_c", ctrl, 32'h310);
    tick();
    rst_n = 1'b0;
    #1;
    check("arst_ctrl", ctrl, 0);
    check("arst_upc", upc, 0);
    check("arst_busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();
    check("arst_idle", {busy, done, error}, 3'b000);
    pulse_start();
    check("rerun_c0", ctrl, 32'h310);
    step_upc("rerun_127", 127);
    check("rerun_127_c", ctrl, 32'h7F);
    do_reset();

    // start and ld_we together: load wins, no run
    start = 1'b1; ld_we = 1'b1; ld_addr = 0; ld_data = mw(0, OP_HALT, 0, 32'h55);
    tick();
    start = 1'b0; ld_we = 1'b0;
    check("both_no_run", busy, 0);
    check("both_ctrl", ctrl, 0);
    pulse_start();
    check("both_loaded", ctrl, 32'h55);
    tick(); check("both_done", done, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
